// File: rtl/trng_seq_ctrl.sv
// Sequencing controller for a ring-oscillator TRNG: warm-up, Von Neumann byte
// collection, FIFO push with backpressure, and a repetition-count health test.
module trng_seq_ctrl #(
  parameter int WARMUP_CYCLES = 64,
  parameter int RCT_LIMIT     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       clear_fail,
  input  logic       raw_bit,
  input  logic       pp_valid,
  input  logic       fifo_full,
  output logic       enable_ro,
  output logic       enable_pp,
  output logic       enable_shift,
  output logic       enable_fifo,
  output logic [2:0] delay_cfg,
  output logic       busy,
  output logic       health_fail
);

  typedef enum logic [2:0] {IDLE, WARMUP, COLLECT, PUSH, FAIL} state_t;

  localparam logic [9:0] WARM_LAST = 10'(WARMUP_CYCLES - 1);
  localparam logic [7:0] RCT_MAX   = 8'(RCT_LIMIT);

  state_t     state, state_next;
  logic [9:0] warm_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] rct_cnt, rct_next;
  logic       prev_bit;
  logic       rct_active, rct_hit, byte_done, write_ok;

  // A zero count means no sample has been seen yet since the counters were cleared.
  always_comb begin
    rct_active = (state == COLLECT) || (state == PUSH);
    if (rct_cnt == 8'd0 || raw_bit != prev_bit)
      rct_next = 8'd1;
    else if (rct_cnt == RCT_MAX)
      rct_next = RCT_MAX;
    else
      rct_next = rct_cnt + 8'd1;
    rct_hit   = rct_active && (rct_next == RCT_MAX);
    byte_done = pp_valid && (bit_cnt == 3'd7);
    write_ok  = (state == PUSH) && !fifo_full && !rct_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Health failure outranks every other transition, including run dropping.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run) state_next = WARMUP;
      WARMUP:  if (!run) state_next = IDLE;
               else if (warm_cnt == WARM_LAST) state_next = COLLECT;
      COLLECT: if (rct_hit) state_next = FAIL;
               else if (!run) state_next = IDLE;
               else if (byte_done) state_next = PUSH;
      PUSH:    if (rct_hit) state_next = FAIL;
               else if (!fifo_full) state_next = run ? COLLECT : IDLE;
      FAIL:    if (clear_fail) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    enable_ro    = 1'b0;
    enable_pp    = 1'b0;
    enable_shift = 1'b0;
    enable_fifo  = 1'b0;
    busy         = (state != IDLE);
    health_fail  = (state == FAIL);
    case (state)
      WARMUP:  enable_ro = 1'b1;
      COLLECT: begin
        enable_ro    = 1'b1;
        enable_pp    = 1'b1;
        enable_shift = pp_valid;
      end
      PUSH: begin
        enable_ro   = 1'b1;
        enable_fifo = !fifo_full && !rct_hit;
      end
      default: ;
    endcase
  end

  // Counters are cleared while idle so every run starts from a fresh warm-up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_cnt  <= '0;
      bit_cnt   <= '0;
      rct_cnt   <= '0;
      prev_bit  <= 1'b0;
      delay_cfg <= '0;
    end else begin
      case (state)
        IDLE: begin
          warm_cnt <= '0;
          bit_cnt  <= '0;
          rct_cnt  <= '0;
        end
        WARMUP:  warm_cnt <= warm_cnt + 10'd1;
        COLLECT: begin
          if (!run)          bit_cnt <= '0;
          else if (pp_valid) bit_cnt <= bit_cnt + 3'd1;
        end
        default: ;
      endcase
      if (rct_active) begin
        rct_cnt  <= rct_next;
        prev_bit <= raw_bit;
      end
      if (write_ok) delay_cfg <= delay_cfg + 3'd1;
    end
  end

endmodule
